pipe_collision: RTL
===================

Name: pipe_collision

Overview:
- Obstacle and collision stage directly downstream of the bird flight-physics block.
- Consumes the bird bounding box (Bird_X_L/X_R/Y_T/Y_B) and owns two scrolling pipe columns with random gap heights.
- Detects bird/pipe and bird/floor overlap, counts passed pipes, and drives Stop back to the physics block.
- Its pipe coordinates also feed the VGA renderer.

Parameters:
- SCREEN_H, 480, floor Y; Bird_Y_B >= SCREEN_H is a floor hit.
- PIPE_W, 40, pipe width in pixels.
- GAP_H, 120, vertical gap height in pixels.
- GAP_MIN, 40, minimum GapTop value.
- SPEED, 2, pixels the pipes move left per FrameTick.
- PIPE_SPACING, 320, horizontal distance used when a pipe respawns.
- INIT_X0, 640, reset and idle X of pipe 0.
- INIT_X1, 960, reset and idle X of pipe 1.
- INIT_GAP, 180, reset and idle GapTop of both pipes.

Ports:
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- Start  in  1  leave Idle and begin a run
- Ack  in  1  acknowledge Hit, return to Idle
- FrameTick  in  1  one-cycle pulse per video frame
- Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B  in  10 each  bird box, unsigned pixels
- Pipe0_X, Pipe1_X  out  10 each  pipe left edge
- Pipe0_GapTop, Pipe1_GapTop  out  10 each  first Y row of the gap
- Stop  out  1  collision occurred; level signal
- Score  out  8  pipes passed; saturates at 255
- q_Idle, q_Run, q_Hit  out  1 each  one-hot state

Behaviour:
- Interface: reset is asynchronous and active-high; the clock is Clk.
- Reset values:
  - state=Idle; Pipe0_X=INIT_X0; Pipe1_X=INIT_X1; both GapTops=INIT_GAP.
  - Score=0; Stop=0; LFSR=8'hA5.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every clock in all states, so gap heights depend on Start timing.
- Pipe geometry:
  - A pipe occupies columns X..X+PIPE_W-1.
  - Solid rows are Y < GapTop and Y > GapTop+GAP_H-1.
  - X values >= 640 are off-screen right and are legal.
- Idle:
  - Pipes are held at their reset positions and gaps.
  - Stop=0. Score holds its last value.
  - Start -> Run next cycle; Score cleared to 0 on entry.
- Run, on FrameTick with no hit detected this cycle:
  - Each pipe: if X < SPEED, respawn. Otherwise X <= X - SPEED.
  - Respawn: X <= (other pipe's post-update X) + PIPE_SPACING; GapTop <= GAP_MIN + LFSR[7:0].
  - Pipe 0 is evaluated first; pipe 1's respawn uses pipe 0's new X.
  - The pipe disappears abruptly when it respawns. This is accepted.
  - Score: +1 when X_old+PIPE_W >= Bird_X_L and X_new+PIPE_W < Bird_X_L. At most once per pipe pass. Both pipes passing on the same tick -> +2. Saturates at 255.
- Run, collision check (every cycle, using registered pipe values):
  - Pipe hit = Bird_X_R >= X && Bird_X_L <= X+PIPE_W-1 && (Bird_Y_T < GapTop || Bird_Y_B > GapTop+GAP_H-1).
  - Floor hit = Bird_Y_B >= SCREEN_H.
  - Any hit -> Hit next cycle; Stop=1 from that cycle.
  - Hit and FrameTick in the same cycle: the hit wins; pipe movement and score update for that tick are suppressed.
- Run ignores Start and Ack.
- Hit:
  - Pipes and Score frozen; Stop=1.
  - Ack -> Idle next cycle: Stop=0, pipes reloaded to INIT values, Score held.
  - Start is ignored in Hit.
- Width rules: all compares are unsigned 10-bit; GapTop+GAP_H max = 295+120 = 415, so no overflow.
- Reset mid-run: immediate return to reset values regardless of state.

Test Plan:
- Reset, then Start. Bird held at X 300..320, Y 220..240. Apply 191 FrameTicks -> Pipe0_X=258, Score=1, Stop=0 throughout.
- Bird Y 100..120, Start, 160 FrameTicks -> Pipe0_X=320; Stop=1 within 2 cycles, q_Hit=1; further ticks leave Pipe0_X=320.
- From the Hit state above, pulse Ack -> q_Idle next cycle, Stop=0, Pipe0_X=640, Pipe1_X=960, Score holds its previous value (0).
- Bird Y 220..240, Start, 321 ticks -> Pipe0 respawns at X=318+320=638, GapTop in 40..295; Score=1; at tick 351 Score=2.
- In Run, drive Bird_Y_B=480 together with a FrameTick -> Stop=1 within 2 cycles; pipe X unchanged on that tick.
- Assert reset mid-Run (Score=1) -> all outputs immediately return to reset values; Start afterwards resumes normally.

Source files
------------

// File: rtl/pipe_collision.sv
// Obstacle/collision stage: two scrolling pipe columns with LFSR-driven gap heights,
// bird/pipe and bird/floor hit detection, pass scoring and the Stop level back to physics.
module pipe_collision #(
   parameter int unsigned SCREEN_H     = 480,
   parameter int unsigned PIPE_W       = 40,
   parameter int unsigned GAP_H        = 120,
   parameter int unsigned GAP_MIN      = 40,
   parameter int unsigned SPEED        = 2,
   parameter int unsigned PIPE_SPACING = 320,
   parameter int unsigned INIT_X0      = 640,
   parameter int unsigned INIT_X1      = 960,
   parameter int unsigned INIT_GAP     = 180
) (
   input  logic       Clk,
   input  logic       reset,
   input  logic       Start,
   input  logic       Ack,
   input  logic       FrameTick,
   input  logic [9:0] Bird_X_L,
   input  logic [9:0] Bird_X_R,
   input  logic [9:0] Bird_Y_T,
   input  logic [9:0] Bird_Y_B,
   output logic [9:0] Pipe0_X,
   output logic [9:0] Pipe1_X,
   output logic [9:0] Pipe0_GapTop,
   output logic [9:0] Pipe1_GapTop,
   output logic       Stop,
   output logic [7:0] Score,
   output logic       q_Idle,
   output logic       q_Run,
   output logic       q_Hit
);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_RUN  = 3'b010,
      S_HIT  = 3'b100
   } state_t;

   localparam logic [9:0]  X0_INIT  = 10'(INIT_X0);
   localparam logic [9:0]  X1_INIT  = 10'(INIT_X1);
   localparam logic [9:0]  GAP_INIT = 10'(INIT_GAP);
   localparam logic [9:0]  SPD      = 10'(SPEED);
   localparam logic [9:0]  SPACING  = 10'(PIPE_SPACING);
   localparam logic [9:0]  GMIN     = 10'(GAP_MIN);
   localparam logic [10:0] W11      = 11'(PIPE_W);
   localparam logic [10:0] GH11     = 11'(GAP_H);
   localparam logic [10:0] FLOOR11  = 11'(SCREEN_H);

   state_t     state_q, state_d;
   logic [9:0] x0_q, x0_d, x1_q, x1_d;
   logic [9:0] g0_q, g0_d, g1_q, g1_d;
   logic [7:0] score_q, score_d;
   logic [7:0] lfsr_q, lfsr_d;

   logic       hit0, hit1, floor_hit, any_hit;
   logic       resp0, resp1, pass0, pass1;
   logic [9:0] x1_dec, x0_mv, x1_mv, gap_new;
   logic [8:0] score_sum;
   logic [7:0] score_sat;

   // Compares are widened to 11 bits so X+PIPE_W and GapTop+GAP_H cannot wrap.
   function automatic logic pipe_hit(input logic [9:0] x, input logic [9:0] g,
                                     input logic [9:0] xl, input logic [9:0] xr,
                                     input logic [9:0] yt, input logic [9:0] yb);
      logic [10:0] right, bottom;
      right  = {1'b0, x} + W11 - 11'd1;
      bottom = {1'b0, g} + GH11 - 11'd1;
      return ({1'b0, xr} >= {1'b0, x}) && ({1'b0, xl} <= right) &&
             (({1'b0, yt} < {1'b0, g}) || ({1'b0, yb} > bottom));
   endfunction

   function automatic logic pipe_pass(input logic [9:0] x_old, input logic [9:0] x_new,
                                      input logic [9:0] xl);
      return (({1'b0, x_old} + W11) >= {1'b0, xl}) && (({1'b0, x_new} + W11) < {1'b0, xl});
   endfunction

   always_comb begin
      hit0      = pipe_hit(x0_q, g0_q, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B);
      hit1      = pipe_hit(x1_q, g1_q, Bird_X_L, Bird_X_R, Bird_Y_T, Bird_Y_B);
      floor_hit = ({1'b0, Bird_Y_B} >= FLOOR11);
      any_hit   = hit0 | hit1 | floor_hit;
   end

   // Pipe 0 respawns behind pipe 1's moved position; pipe 1 respawns behind pipe 0's new one.
   always_comb begin
      resp0     = (x0_q < SPD);
      resp1     = (x1_q < SPD);
      x1_dec    = x1_q - SPD;
      x0_mv     = resp0 ? (x1_dec + SPACING) : (x0_q - SPD);
      x1_mv     = resp1 ? (x0_mv + SPACING) : x1_dec;
      gap_new   = GMIN + {2'b00, lfsr_q};
      pass0     = pipe_pass(x0_q, x0_mv, Bird_X_L);
      pass1     = pipe_pass(x1_q, x1_mv, Bird_X_L);
      score_sum = {1'b0, score_q} + {8'd0, pass0} + {8'd0, pass1};
      score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
   end

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      x1_d    = x1_q;
      g0_d    = g0_q;
      g1_d    = g1_q;
      score_d = score_q;
      lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      case (state_q)
         S_IDLE: begin
            x0_d = X0_INIT;
            x1_d = X1_INIT;
            g0_d = GAP_INIT;
            g1_d = GAP_INIT;
            if (Start) begin
               state_d = S_RUN;
               score_d = '0;
            end
         end
         S_RUN: begin
            if (any_hit) begin
               state_d = S_HIT;
            end else if (FrameTick) begin
               x0_d    = x0_mv;
               x1_d    = x1_mv;
               if (resp0) g0_d = gap_new;
               if (resp1) g1_d = gap_new;
               score_d = score_sat;
            end
         end
         S_HIT: begin
            if (Ack) begin
               state_d = S_IDLE;
               x0_d    = X0_INIT;
               x1_d    = X1_INIT;
               g0_d    = GAP_INIT;
               g1_d    = GAP_INIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         x0_q    <= X0_INIT;
         x1_q    <= X1_INIT;
         g0_q    <= GAP_INIT;
         g1_q    <= GAP_INIT;
         score_q <= '0;
         lfsr_q  <= 8'hA5;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         x1_q    <= x1_d;
         g0_q    <= g0_d;
         g1_q    <= g1_d;
         score_q <= score_d;
         lfsr_q  <= lfsr_d;
      end
   end

   always_comb begin
      Pipe0_X      = x0_q;
      Pipe1_X      = x1_q;
      Pipe0_GapTop = g0_q;
      Pipe1_GapTop = g1_q;
      Score        = score_q;
      Stop         = (state_q == S_HIT);
      q_Idle       = (state_q == S_IDLE);
      q_Run        = (state_q == S_RUN);
      q_Hit        = (state_q == S_HIT);
   end

endmodule
